// File: rtl/icache_intc_resp_node_pkg.sv
// Shared constants, width helpers and the response record for the icache interconnect responder.
package icache_intc_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int UID_W_DEF  = 16;
    localparam int DATA_W_DEF = 128;
    localparam int DEPTH_DEF  = 4;

    function automatic int calc_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int calc_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int PTR_W = calc_ptr_w(DEPTH_DEF);
    localparam int CNT_W = calc_cnt_w(DEPTH_DEF);

    // Optional output register contents; widths follow the default data/UID widths.
    typedef struct packed {
        logic                  valid;
        logic [DATA_W_DEF-1:0] data;
        logic [UID_W_DEF-1:0]  uid;
    } resp_t;

endpackage

// File: rtl/icache_intc_resp_node_if.sv
// Request, memory and response signals of the interconnect root responder.
interface icache_intc_resp_node_if
    import icache_intc_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDR_W_DEF,
    parameter int UID_WIDTH     = UID_W_DEF,
    parameter int DATA_WIDTH    = DATA_W_DEF,
    parameter int DEPTH         = DEPTH_DEF
);
    localparam int CW = calc_cnt_w(DEPTH);

    logic                     request_i;
    logic [ADDRESS_WIDTH-1:0] address_i;
    logic [UID_WIDTH-1:0]     UID_i;
    logic                     grant_o;
    logic                     mem_req_o;
    logic [ADDRESS_WIDTH-1:0] mem_addr_o;
    logic                     mem_gnt_i;
    logic                     mem_rvalid_i;
    logic [DATA_WIDTH-1:0]    mem_rdata_i;
    logic                     response_valid_o;
    logic [DATA_WIDTH-1:0]    response_data_o;
    logic [UID_WIDTH-1:0]     response_UID_o;
    logic [CW-1:0]            outstanding_o;
    logic                     error_o;

    modport slave (
        input  request_i, address_i, UID_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output grant_o, mem_req_o, mem_addr_o, response_valid_o, response_data_o,
               response_UID_o, outstanding_o, error_o
    );

    modport master (
        output request_i, address_i, UID_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  grant_o, mem_req_o, mem_addr_o, response_valid_o, response_data_o,
               response_UID_o, outstanding_o, error_o
    );

endinterface

// File: rtl/icache_intc_resp_node_uid_fifo.sv
// In-order UID tracking FIFO with fall-through head; push is ignored when full, pop when empty.
module icache_intc_uid_fifo
    import icache_intc_pkg::*;
#(
    parameter int UID_WIDTH = UID_W_DEF,
    parameter int DEPTH     = DEPTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_push,
    input  logic                           i_pop,
    input  logic [UID_WIDTH-1:0]           i_data,
    output logic [UID_WIDTH-1:0]           o_head,
    output logic                           o_full,
    output logic                           o_empty,
    output logic [calc_cnt_w(DEPTH)-1:0]   o_count
);
    localparam int PW = calc_ptr_w(DEPTH);
    localparam int CW = calc_cnt_w(DEPTH);

    logic [UID_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 w_push;
    logic                 w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed below the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/icache_intc_resp_node.sv
// Root responder of the icache interconnect: issues requests to memory and pairs in-order read data with UIDs.
// Define ICACHE_INTC_RESP_REG_EN to register the response outputs (one extra cycle of latency).
module icache_intc_resp_node
    import icache_intc_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDR_W_DEF,
    parameter int UID_WIDTH     = UID_W_DEF,
    parameter int DATA_WIDTH    = DATA_W_DEF,
    parameter int DEPTH         = DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    icache_intc_resp_node_if.slave  bus
);
    localparam int CW = calc_cnt_w(DEPTH);

    logic                 w_full;
    logic                 w_empty;
    logic                 w_mem_req;
    logic                 w_grant;
    logic                 w_resp_valid;
    logic [UID_WIDTH-1:0] w_head;
    logic [CW-1:0]        w_count;
    logic                 r_error;

    // Grant depends only on the registered count, never on this cycle's rvalid.
    assign w_mem_req    = bus.request_i & ~w_full;
    assign w_grant      = w_mem_req & bus.mem_gnt_i;
    assign w_resp_valid = bus.mem_rvalid_i & ~w_empty;

    assign bus.mem_req_o     = w_mem_req;
    assign bus.grant_o       = w_grant;
    assign bus.mem_addr_o    = bus.address_i;
    assign bus.outstanding_o = w_count;
    assign bus.error_o       = r_error;

    icache_intc_uid_fifo #(
        .UID_WIDTH (UID_WIDTH),
        .DEPTH     (DEPTH)
    ) u_uid_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_grant),
        .i_pop   (bus.mem_rvalid_i),
        .i_data  (bus.UID_i),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_error <= 1'b0;
        end else if (bus.mem_rvalid_i && w_empty) begin
            r_error <= 1'b1;
        end
    end

`ifdef ICACHE_INTC_RESP_REG_EN
    resp_t r_resp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp.valid <= 1'b0;
        end else begin
            r_resp.valid <= w_resp_valid;
            if (w_resp_valid) begin
                r_resp.data <= bus.mem_rdata_i;
                r_resp.uid  <= w_head;
            end
        end
    end

    assign bus.response_valid_o = r_resp.valid;
    assign bus.response_data_o  = r_resp.data;
    assign bus.response_UID_o   = r_resp.uid;
`else
    assign bus.response_valid_o = w_resp_valid;
    assign bus.response_data_o  = bus.mem_rdata_i;
    assign bus.response_UID_o   = w_head;
`endif

endmodule
